// File: rtl/writeback_pkg.sv
// writeback_pkg: shared widths and the queue entry layout {wb, rd_num, data}.
package writeback_pkg;
    localparam int WORD = 32;
    localparam int W_RD = 5;
    typedef struct packed {
        logic            wb;
        logic [W_RD-1:0] rd_num;
        logic [WORD-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: 2-entry result queue with push/pop, full/empty and per-entry read-out for bypass.
module wb_fifo
    import writeback_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  wb_entry_t       din,
    output wb_entry_t       head,
    output logic            full,
    output logic            empty,
    output wb_entry_t [1:0] ents,
    output logic            wptr
);
    logic       rptr;
    logic [1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            cnt        <= 2'd0;
            ents[0].wb <= 1'b0;
            ents[1].wb <= 1'b0;
        end else begin
            if (push) begin
                ents[wptr] <= din;
                wptr       <= ~wptr;
            end
            if (pop)
                rptr <= ~rptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end
    assign head  = ents[rptr];
    assign full  = cnt == 2'd2;
    assign empty = cnt == 2'd0;
endmodule

// File: rtl/writeback.sv
// writeback: buffers execute results and drains them into the register-file write port.
// Define WB_BYPASS_EN to build the decode bypass search over queued results.
module writeback
    import writeback_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            v_i,
    output logic            stall_o,
    input  logic [W_RD-1:0] rd_num_i,
    input  logic            wb_i,
    input  logic [WORD-1:0] rd_data_i,
    input  logic            rf_busy_i,
    output logic            rf_we_o,
    output logic [W_RD-1:0] rf_waddr_o,
    output logic [WORD-1:0] rf_wdata_o,
    input  logic [W_RD-1:0] q_num_i,
    output logic            q_hit_o,
    output logic [WORD-1:0] q_data_o,
    output logic [31:0]     retired_o
);
    wb_entry_t       din, head;
    wb_entry_t [1:0] ents;
    logic            full, empty, wptr, hv, push, pop;
    logic [31:0]     retired;
    assign din  = '{wb: wb_i, rd_num: rd_num_i, data: rd_data_i};
    assign hv   = ~empty;
    assign push = v_i & ~full;
    assign pop  = hv & (~head.wb | ~rf_busy_i);
    wb_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty),
        .ents  (ents),
        .wptr  (wptr)
    );
    always_ff @(posedge clk) begin
        if (rst)
            retired <= 32'd0;
        else if (pop)
            retired <= retired + 32'd1;
    end
    assign stall_o    = full;
    assign retired_o  = retired;
    assign rf_we_o    = hv & head.wb & ~rf_busy_i & ~rst;
    assign rf_waddr_o = hv ? head.rd_num : '0;
    assign rf_wdata_o = hv ? head.data : '0;
`ifdef WB_BYPASS_EN
    // Newest entry sits just behind the write pointer; the older one is valid only when full.
    logic m_new, m_old;
    assign m_new    = hv & ents[~wptr].wb & (ents[~wptr].rd_num == q_num_i) & (q_num_i != '0);
    assign m_old    = full & ents[wptr].wb & (ents[wptr].rd_num == q_num_i) & (q_num_i != '0);
    assign q_hit_o  = m_new | m_old;
    assign q_data_o = m_new ? ents[~wptr].data : m_old ? ents[wptr].data : '0;
`else
    logic unused_byp;
    assign unused_byp = ^{q_num_i, ents, wptr};
    assign q_hit_o    = 1'b0;
    assign q_data_o   = '0;
`endif
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed vector table plus hand-written reset, bypass and counter-wrap sequences.
module tb_writeback;
    logic        clk = 0, rst = 1, v_i = 0, wb_i = 0, rf_busy_i = 0;
    logic [4:0]  rd_num_i = 0, q_num_i = 0;
    logic [31:0] rd_data_i = 0;
    logic        stall_o, rf_we_o, q_hit_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o, q_data_o, retired_o;
    int errors = 0, checks = 0;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    writeback dut (
        .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o), .rd_num_i(rd_num_i),
        .wb_i(wb_i), .rd_data_i(rd_data_i), .rf_busy_i(rf_busy_i), .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .q_num_i(q_num_i),
        .q_hit_o(q_hit_o), .q_data_o(q_data_o), .retired_o(retired_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, wb;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        busy, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        stall;
        logic [31:0] ret;
    } vec_t;
    vec_t tv[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic wb, input logic [4:0] rd, input logic [31:0] d, input logic busy);
        v_i = v; wb_i = wb; rd_num_i = rd; rd_data_i = d; rf_busy_i = busy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = '{1, 1, 3,  32'hDEADBEEF, 0, 0, 0,  32'h0,        0, 0};
        tv[1]  = '{0, 0, 0,  32'h0,        0, 1, 3,  32'hDEADBEEF, 0, 0};
        tv[2]  = '{0, 0, 0,  32'h0,        0, 0, 0,  32'h0,        0, 1};
        tv[3]  = '{1, 1, 5,  32'hA1,       1, 0, 0,  32'h0,        0, 1};
        tv[4]  = '{1, 1, 6,  32'hA2,       1, 0, 5,  32'hA1,       0, 1};
        tv[5]  = '{1, 1, 7,  32'hA3,       1, 0, 5,  32'hA1,       1, 1};
        tv[6]  = '{1, 1, 7,  32'hA3,       0, 1, 5,  32'hA1,       1, 1};
        tv[7]  = '{1, 1, 7,  32'hA3,       0, 1, 6,  32'hA2,       0, 2};
        tv[8]  = '{0, 0, 0,  32'h0,        0, 1, 7,  32'hA3,       0, 3};
        tv[9]  = '{0, 0, 0,  32'h0,        0, 0, 0,  32'h0,        0, 4};
        tv[10] = '{1, 1, 9,  32'hB1,       1, 0, 0,  32'h0,        0, 4};
        tv[11] = '{1, 0, 10, 32'hB2,       1, 0, 9,  32'hB1,       0, 4};
        tv[12] = '{0, 0, 0,  32'h0,        1, 0, 9,  32'hB1,       1, 4};
        tv[13] = '{0, 0, 0,  32'h0,        0, 1, 9,  32'hB1,       1, 4};
        tv[14] = '{0, 0, 0,  32'h0,        1, 0, 10, 32'hB2,       0, 5};
        tv[15] = '{0, 0, 0,  32'h0,        0, 0, 0,  32'h0,        0, 6};
        tv[16] = '{1, 1, 0,  32'hC0,       0, 0, 0,  32'h0,        0, 6};
        tv[17] = '{0, 0, 0,  32'h0,        0, 1, 0,  32'hC0,       0, 6};
        tv[18] = '{0, 0, 0,  32'h0,        0, 0, 0,  32'h0,        0, 7};

        tick(); tick();
        rst = 0;
        #1;
        chk("rst stall", {31'b0, stall_o}, 0);
        chk("rst we", {31'b0, rf_we_o}, 0);
        chk("rst waddr", {27'b0, rf_waddr_o}, 0);
        chk("rst wdata", rf_wdata_o, 0);
        chk("rst hit", {31'b0, q_hit_o}, 0);
        chk("rst retired", retired_o, 0);
        tick();

        for (int i = 0; i < 19; i++) begin
            drive(tv[i].v, tv[i].wb, tv[i].rd, tv[i].d, tv[i].busy);
            #1;
            chk($sformatf("v%0d we", i), {31'b0, rf_we_o}, {31'b0, tv[i].we});
            chk($sformatf("v%0d waddr", i), {27'b0, rf_waddr_o}, {27'b0, tv[i].wa});
            chk($sformatf("v%0d wdata", i), rf_wdata_o, tv[i].wd);
            chk($sformatf("v%0d stall", i), {31'b0, stall_o}, {31'b0, tv[i].stall});
            chk($sformatf("v%0d retired", i), retired_o, tv[i].ret);
            chk($sformatf("v%0d hit", i), {31'b0, q_hit_o}, 0);
            tick();
        end

        // reset with a full queue: nothing may be written
        drive(1, 1, 1, 32'hE1, 1); tick();
        drive(1, 1, 2, 32'hE2, 1); tick();
        drive(0, 0, 0, 0, 1);
        #1;
        chk("full stall", {31'b0, stall_o}, 1);
        rf_busy_i = 0; rst = 1;
        #1;
        chk("we during rst", {31'b0, rf_we_o}, 0);
        tick();
        rst = 0;
        #1;
        chk("post rst stall", {31'b0, stall_o}, 0);
        chk("post rst retired", retired_o, 0);
        chk("post rst we", {31'b0, rf_we_o}, 0);
        chk("post rst waddr", {27'b0, rf_waddr_o}, 0);
        tick();
        chk("post rst we2", {31'b0, rf_we_o}, 0);

        // bypass: two pending writes to r7, newest must win
        drive(1, 1, 7, 32'h11, 1); tick();
        drive(1, 1, 7, 32'h22, 1); tick();
        drive(0, 0, 0, 0, 1);
        q_num_i = 7;
        #1;
        chk("byp hit7", {31'b0, q_hit_o}, {31'b0, BYP});
        chk("byp data7", q_data_o, BYP ? 32'h22 : 32'h0);
        q_num_i = 0;
        #1;
        chk("byp hit0", {31'b0, q_hit_o}, 0);
        chk("byp data0", q_data_o, 0);
        q_num_i = 5;
        #1;
        chk("byp hit5", {31'b0, q_hit_o}, 0);
        rf_busy_i = 0;
        tick();
        q_num_i = 7;
        #1;
        chk("byp after pop hit", {31'b0, q_hit_o}, {31'b0, BYP});
        chk("byp after pop data", q_data_o, BYP ? 32'h22 : 32'h0);
        tick();
        chk("byp empty hit", {31'b0, q_hit_o}, 0);
        chk("byp empty data", q_data_o, 0);
        chk("byp retired", retired_o, 2);

        // counter wrap
        drive(1, 1, 4, 32'h44, 1); tick();
        drive(0, 0, 0, 0, 1);
        force dut.retired = 32'hFFFFFFFF;
        #1;
        release dut.retired;
        #1;
        chk("wrap pre", retired_o, 32'hFFFFFFFF);
        rf_busy_i = 0;
        tick();
        chk("wrap post", retired_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
